ninjakun_slot_sched: RTL
========================

# ninjakun_slot_sched

Time-slot scheduler for the 48 MHz master clock domain. A 16-phase counter generates single-cycle clock enables (24/12/6/3 MHz rates) and shares one synchronous single-port RAM between the video fetch path and two CPU requesters. Video owns fixed slots. The two CPUs compete for the remaining slots via a req/ack handshake. It sits between the CPUs and the video generator on one side and the shared work/video RAM on the other.

## Interface
Parameters:
- AW, 11, RAM address width
- DW, 8, RAM data width

Ports:
- MCLK  in  1  master clock, 48 MHz; the block's only clock
- RESETn  in  1  synchronous, active-low reset
- PHASE  out  4  phase counter P
- CE24, CE12, CE6, CE3  out  1 each  clock-enable pulses
- VID_ADDR  in  AW  video fetch address
- VID_DATA  out  DW  fetched video data
- VID_VALID  out  1  VID_DATA updated (1-cycle pulse)
- CPUn_REQ  in  1  access request (n = 0, 1)
- CPUn_WE  in  1  1 = write, 0 = read
- CPUn_ADDR  in  AW  CPU address
- CPUn_WDATA  in  DW  write data
- CPUn_ACK  out  1  access-complete pulse
- CPUn_RDATA  out  DW  read data, valid while CPUn_ACK is high
- RAM_ADDR  out  AW  RAM address (registered)
- RAM_WE  out  1  RAM write strobe (registered)
- RAM_WDATA  out  DW  RAM write data (registered)
- RAM_RDATA  in  DW  RAM read data; valid 1 cycle after its address

## Operation
- P increments by 1 every MCLK and wraps 15 -> 0.
- Clock enables, each high for one MCLK cycle:
  - CE24 = P[0]
  - CE12 = (P[1:0]==3)
  - CE6 = (P[2:0]==7)
  - CE3 = (P==15)
- Slot types, by P[1:0]:
  - 0: video slot (V)
  - 2: CPU slot (C)
  - 1 and 3: idle. RAM_WE is driven to 0 in the cycle after an idle slot; RAM_ADDR and RAM_WDATA hold.
- Video slot:
  - VID_ADDR is sampled at the end of V.
  - RAM_ADDR = VID_ADDR and RAM_WE = 0 during V+1.
  - RAM_RDATA is captured into VID_DATA at the end of V+2.
  - VID_VALID is high during V+3.
  - Video is never stalled.
- CPU slot arbitration:
  - At the end of C, candidates are requesters with REQ=1 and no transaction in flight.
  - One candidate: it is granted.
  - Two candidates: the requester not granted last time wins (round-robin).
  - No candidate: the slot is idle.
- Granted access:
  - RAM_ADDR = CPUn_ADDR, RAM_WDATA = CPUn_WDATA and RAM_WE = CPUn_WE during C+1.
  - For reads, RAM_RDATA is captured into CPUn_RDATA at the end of C+2.
  - CPUn_ACK is high during C+3 for both reads and writes.
  - CPUn_RDATA holds until that requester's next read completes. Writes leave it unchanged.
- Handshake:
  - The requester holds REQ, WE, ADDR and WDATA stable from REQ assertion until its ACK cycle.
  - REQ still high at the next C slot after ACK is treated as a new request.
  - Peak throughput is one CPU access per 4 cycles (12 MHz aggregate).
- Round-robin pointer: records the last granted CPU. Reset value points to CPU1, so CPU0 wins the first conflict.

## Timing
- Reset (RESETn=0 at a rising MCLK edge) forces the following on the next cycle:
  - P=0; all CE outputs computed from P=0 (CE24=0)
  - VID_VALID=0, CPUn_ACK=0
  - RAM_WE=0, RAM_ADDR=0, RAM_WDATA=0
  - VID_DATA=0, CPUn_RDATA=0
  - in-flight flags cleared, RR pointer = CPU1
- Reset mid-transaction: the transaction is cancelled and no ACK is issued. A write already strobed in the RAM remains committed.
- Latencies:
  - Video: address sampled at V, data valid 3 cycles later.
  - CPU: 3 cycles from grant to ACK; worst-case REQ-to-ACK is 3 + 3 + 4 = 10 cycles under contention.
- Simultaneous events:
  - REQ rising exactly in a C cycle counts for that slot.
  - REQ dropped before ACK is illegal (behaviour unspecified).
- First video slot after reset is P=4. P=0 in the reset-release cycle is the slot cycle itself, so the first VID_VALID appears at P=7.

## Configuration
- NINJAKUN_SCHED_FIXPRIO_EN:
  - Defined: CPU0 always wins conflicts and the RR pointer is not implemented.
  - Undefined: round-robin as described above.

## Test plan
- Reset release, no requests: PHASE counts 0..15 and wraps; CE24 high on odd P, CE12 at P=3,7,11,15, CE6 at P=7,15, CE3 at P=15; VID_VALID at P=3,7,11,15 except the first frame's first slot.
- Video fetch with RAM model preloaded mem[0x123]=0xA5 and VID_ADDR=0x123: VID_DATA=0xA5 with VID_VALID 3 cycles after the P=4 slot.
- CPU0 writes 0x5A to 0x040, then reads it back: RAM_WE pulse at P=3, ACK at P=5; read ACK with CPU0_RDATA=0x5A.
- Both CPUs hold REQ continuously:
  - Without the macro, grants alternate CPU0, CPU1, CPU0…
  - With NINJAKUN_SCHED_FIXPRIO_EN, CPU1 never gets a grant while CPU0 keeps REQ high.
- Reset asserted during C+1 of a CPU1 read: no CPU1_ACK; after release, outputs are at their reset values and the next request completes normally.
- Video and CPU interleaving: video reads 0x000..0x00F while CPU1 writes 0x7FF; every VID_VALID has correct data and no RAM_WE occurs outside a C+1 cycle.

Source files
------------

// File: rtl/ninjakun_slot_sched.sv
// rtl/ninjakun_slot_sched.sv - 16-phase slot scheduler sharing one RAM between video and two CPUs
// Optional macro NINJAKUN_SCHED_FIXPRIO_EN: CPU0 always wins conflicts, no round-robin pointer.
module ninjakun_slot_sched #(
  parameter int AW = 11,
  parameter int DW = 8
) (
  input  logic          MCLK,
  input  logic          RESETn,
  output logic [3:0]    PHASE,
  output logic          CE24,
  output logic          CE12,
  output logic          CE6,
  output logic          CE3,
  input  logic [AW-1:0] VID_ADDR,
  output logic [DW-1:0] VID_DATA,
  output logic          VID_VALID,
  input  logic          CPU0_REQ,
  input  logic          CPU0_WE,
  input  logic [AW-1:0] CPU0_ADDR,
  input  logic [DW-1:0] CPU0_WDATA,
  output logic          CPU0_ACK,
  output logic [DW-1:0] CPU0_RDATA,
  input  logic          CPU1_REQ,
  input  logic          CPU1_WE,
  input  logic [AW-1:0] CPU1_ADDR,
  input  logic [DW-1:0] CPU1_WDATA,
  output logic          CPU1_ACK,
  output logic [DW-1:0] CPU1_RDATA,
  output logic [AW-1:0] RAM_ADDR,
  output logic          RAM_WE,
  output logic [DW-1:0] RAM_WDATA,
  input  logic [DW-1:0] RAM_RDATA
);

  logic [3:0]    phase;
  logic          started;
  logic          slot_v;
  logic          slot_c;

  logic          vid_s1;
  logic          vid_s2;

  logic [1:0]    cand;
  logic          grant_any;
  logic          grant_id;
  logic          sel_we;
  logic [AW-1:0] sel_addr;
  logic [DW-1:0] sel_wdata;

  logic          cpu_s1;
  logic          cpu_s2;
  logic          cpu_id1;
  logic          cpu_id2;
  logic          cpu_we1;
  logic          cpu_we2;
  logic [1:0]    in_flight;

`ifndef NINJAKUN_SCHED_FIXPRIO_EN
  logic          rr_last;
`endif

  assign PHASE = phase;
  assign CE24  = phase[0];
  assign CE12  = &phase[1:0];
  assign CE6   = &phase[2:0];
  assign CE3   = &phase;

  // The P=0 slot of the reset-release cycle is skipped, so video starts at P=4.
  assign slot_v = started && (phase[1:0] == 2'd0);
  assign slot_c = (phase[1:0] == 2'd2);

  always_comb begin
    cand      = 2'b00;
    grant_any = 1'b0;
    grant_id  = 1'b0;
    if (slot_c) begin
      cand = {CPU1_REQ & ~in_flight[1], CPU0_REQ & ~in_flight[0]};
    end
    grant_any = |cand;
`ifdef NINJAKUN_SCHED_FIXPRIO_EN
    grant_id = ~cand[0];
`else
    if (&cand) begin
      grant_id = ~rr_last;
    end else begin
      grant_id = ~cand[0];
    end
`endif
  end

  assign sel_we    = grant_id ? CPU1_WE    : CPU0_WE;
  assign sel_addr  = grant_id ? CPU1_ADDR  : CPU0_ADDR;
  assign sel_wdata = grant_id ? CPU1_WDATA : CPU0_WDATA;

  always_ff @(posedge MCLK) begin
    if (!RESETn) begin
      phase   <= 4'd0;
      started <= 1'b0;
    end else begin
      phase   <= phase + 4'd1;
      started <= 1'b1;
    end
  end

  // RAM port: video address in V+1, granted CPU access in C+1, strobe low otherwise.
  always_ff @(posedge MCLK) begin
    if (!RESETn) begin
      RAM_ADDR  <= '0;
      RAM_WE    <= 1'b0;
      RAM_WDATA <= '0;
    end else begin
      RAM_WE <= 1'b0;
      if (slot_v) begin
        RAM_ADDR <= VID_ADDR;
      end else if (grant_any) begin
        RAM_ADDR  <= sel_addr;
        RAM_WDATA <= sel_wdata;
        RAM_WE    <= sel_we;
      end
    end
  end

  always_ff @(posedge MCLK) begin
    if (!RESETn) begin
      vid_s1    <= 1'b0;
      vid_s2    <= 1'b0;
      VID_VALID <= 1'b0;
      VID_DATA  <= '0;
    end else begin
      vid_s1    <= slot_v;
      vid_s2    <= vid_s1;
      VID_VALID <= vid_s2;
      if (vid_s2) begin
        VID_DATA <= RAM_RDATA;
      end
    end
  end

  always_ff @(posedge MCLK) begin
    if (!RESETn) begin
      cpu_s1     <= 1'b0;
      cpu_s2     <= 1'b0;
      cpu_id1    <= 1'b0;
      cpu_id2    <= 1'b0;
      cpu_we1    <= 1'b0;
      cpu_we2    <= 1'b0;
      CPU0_ACK   <= 1'b0;
      CPU1_ACK   <= 1'b0;
      CPU0_RDATA <= '0;
      CPU1_RDATA <= '0;
    end else begin
      cpu_s1   <= grant_any;
      cpu_id1  <= grant_id;
      cpu_we1  <= sel_we;
      cpu_s2   <= cpu_s1;
      cpu_id2  <= cpu_id1;
      cpu_we2  <= cpu_we1;
      CPU0_ACK <= cpu_s2 && !cpu_id2;
      CPU1_ACK <= cpu_s2 && cpu_id2;
      if (cpu_s2 && !cpu_we2 && !cpu_id2) begin
        CPU0_RDATA <= RAM_RDATA;
      end
      if (cpu_s2 && !cpu_we2 && cpu_id2) begin
        CPU1_RDATA <= RAM_RDATA;
      end
    end
  end

  // A requester stays out of arbitration from its grant until the end of its ACK cycle.
  always_ff @(posedge MCLK) begin
    if (!RESETn) begin
      in_flight <= 2'b00;
    end else begin
      if (grant_any && !grant_id) begin
        in_flight[0] <= 1'b1;
      end else if (CPU0_ACK) begin
        in_flight[0] <= 1'b0;
      end
      if (grant_any && grant_id) begin
        in_flight[1] <= 1'b1;
      end else if (CPU1_ACK) begin
        in_flight[1] <= 1'b0;
      end
    end
  end

`ifndef NINJAKUN_SCHED_FIXPRIO_EN
  always_ff @(posedge MCLK) begin
    if (!RESETn) begin
      rr_last <= 1'b1;
    end else if (grant_any) begin
      rr_last <= grant_id;
    end
  end
`endif

endmodule
